// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the buffered UART transmitter:
//   - transmit FSM state encoding
//   - parity-type constants for PAR_TYP
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
  localparam logic [2:0] ST_START_ENC  = 3'd1;
  localparam logic [2:0] ST_DATA_ENC   = 3'd2;
  localparam logic [2:0] ST_PARITY_ENC = 3'd3;
  localparam logic [2:0] ST_STOP_ENC   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_START  = ST_START_ENC,
    ST_DATA   = ST_DATA_ENC,
    ST_PARITY = ST_PARITY_ENC,
    ST_STOP   = ST_STOP_ENC
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_sync_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_sync_fifo
//   Single-clock FIFO holding words waiting to be transmitted.
//   Ports:
//     clk_i, rst_i    clock, asynchronous active-high reset (empties FIFO)
//     push_i          write wr_data_i (ignored when full)
//     wr_data_i       word to write
//     pop_i           advance read pointer (ignored when empty)
//     rd_data_o       word at the head of the FIFO (valid when !empty_o)
//     full_o/empty_o  status flags
//     count_o         words currently stored
// ---------------------------------------------------------------------------
module uart_tx_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          push_i,
  input  logic [DATA_WIDTH-1:0]         wr_data_i,
  input  logic                          pop_i,
  output logic [DATA_WIDTH-1:0]         rd_data_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  push_ok, pop_ok;

  assign full_o    = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_o   = (count_q == '0);
  assign push_ok   = push_i && !full_o;
  assign pop_ok    = pop_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: contents are only read behind a valid count.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// ---------------------------------------------------------------------------
// uart_tx_buffered
//   UART transmitter with an input FIFO. Frames are start bit, DATA_WIDTH
//   data bits LSB first, optional parity, STOP_BITS stop bits; queued words
//   go out back to back. All FSM progress is gated by BAUD_TICK.
//
//   state  | meaning
//   IDLE   | line high, waiting for a queued word
//   START  | start bit (0) on the line
//   DATA   | data bits, LSB first
//   PARITY | parity bit
//   STOP   | stop bit(s) (1)
//
//   Ports:
//     CLK, RST     clock, asynchronous active-high reset
//     BAUD_TICK    one-cycle strobe per bit period
//     P_DATA       word to queue, written when DATA_VALID && DATA_READY
//     DATA_VALID   P_DATA valid
//     DATA_READY   FIFO not full
//     PAR_EN       parity enable (latched at frame start)
//     PAR_TYP      0 even / 1 odd (latched at frame start)
//     TX_OUT       registered serial line, idle high
//     BUSY         frame in progress
//     FIFO_COUNT   words queued
// ---------------------------------------------------------------------------
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          BAUD_TICK,
  input  logic [DATA_WIDTH-1:0]         P_DATA,
  input  logic                          DATA_VALID,
  output logic                          DATA_READY,
  input  logic                          PAR_EN,
  input  logic                          PAR_TYP,
  output logic                          TX_OUT,
  output logic                          BUSY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT
);

  localparam int BCW = $clog2(DATA_WIDTH + 1);

  tx_state_e             state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [BCW-1:0]        bit_cnt_q;
  logic                  stop_cnt_q;
  logic                  par_en_q;
  logic                  par_bit_q;
  logic                  tx_q;

  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_full, fifo_empty;
  logic                  stop_last;
  logic                  pop_d;
  logic                  par_bit_d;

  assign stop_last = (stop_cnt_q == 1'b0);

  // A word leaves the FIFO when a frame starts, either from IDLE or straight
  // out of the last stop bit. Empty is the pre-push view, so a word written
  // this edge is never popped on the same edge.
  assign pop_d = BAUD_TICK && !fifo_empty &&
                 ((state_q == ST_IDLE) || ((state_q == ST_STOP) && stop_last));

  assign par_bit_d = (^fifo_rd_data) ^ (PAR_TYP == PAR_ODD);

  uart_tx_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (CLK),
    .rst_i     (RST),
    .push_i    (DATA_VALID),
    .wr_data_i (P_DATA),
    .pop_i     (pop_d),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (FIFO_COUNT)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      tx_q       <= 1'b1;
    end else if (BAUD_TICK) begin
      unique case (state_q)
        ST_IDLE: begin
          if (pop_d) begin
            state_q   <= ST_START;
            shift_q   <= fifo_rd_data;
            par_en_q  <= PAR_EN;
            par_bit_q <= par_bit_d;
            tx_q      <= 1'b0;
          end
        end
        ST_START: begin
          state_q   <= ST_DATA;
          tx_q      <= shift_q[0];
          shift_q   <= {1'b0, shift_q[DATA_WIDTH-1:1]};
          bit_cnt_q <= BCW'(DATA_WIDTH - 1);
        end
        ST_DATA: begin
          // bit_cnt_q counts data bits still to be placed on the line.
          if (bit_cnt_q == '0) begin
            if (par_en_q) begin
              state_q <= ST_PARITY;
              tx_q    <= par_bit_q;
            end else begin
              state_q    <= ST_STOP;
              tx_q       <= 1'b1;
              stop_cnt_q <= 1'(STOP_BITS - 1);
            end
          end else begin
            tx_q      <= shift_q[0];
            shift_q   <= {1'b0, shift_q[DATA_WIDTH-1:1]};
            bit_cnt_q <= bit_cnt_q - 1'b1;
          end
        end
        ST_PARITY: begin
          state_q    <= ST_STOP;
          tx_q       <= 1'b1;
          stop_cnt_q <= 1'(STOP_BITS - 1);
        end
        ST_STOP: begin
          if (!stop_last) begin
            stop_cnt_q <= stop_cnt_q - 1'b1;
          end else if (pop_d) begin
            state_q   <= ST_START;
            shift_q   <= fifo_rd_data;
            par_en_q  <= PAR_EN;
            par_bit_q <= par_bit_d;
            tx_q      <= 1'b0;
          end else begin
            state_q <= ST_IDLE;
            tx_q    <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign TX_OUT     = tx_q;
  assign BUSY       = (state_q != ST_IDLE);
  assign DATA_READY = !fifo_full;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_buffered
//   Directed bench. dut1: W=8, depth 4, 1 stop bit. dut2: same with 2 stop
//   bits. Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_uart_tx_buffered;

  logic       clk = 1'b0;
  logic       rst, tick;
  logic [7:0] p_data, p_data2;
  logic       valid, valid2, ready, ready2;
  logic       par_en, par_en2, par_typ, par_typ2;
  logic       tx, tx2, busy, busy2;
  logic [2:0] count, count2;

  int n_assert = 0;
  int n_fail   = 0;

  // Expected line sequences, index 0 first on the line.
  logic [10:0] t1_exp = 11'b10101001010;   // 0xA5, even parity 0
  logic [10:0] t2_exp = 11'b11101001010;   // 0xA5, odd parity 1
  logic [21:0] t3_exp = {10'h3FF, 1'b0, 2'b11, 9'h000};
  logic [10:0] t5_exp = 11'b10001111000;   // 0x3C, even parity 0
  logic [9:0]  t6_exp = 10'b1010110100;    // 0x5A, no parity
  logic [7:0]  t4_w [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [9:0]  fr;

  always #5 clk = ~clk;

  uart_tx_buffered #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .STOP_BITS(1)) dut1 (
    .CLK(clk), .RST(rst), .BAUD_TICK(tick), .P_DATA(p_data), .DATA_VALID(valid),
    .DATA_READY(ready), .PAR_EN(par_en), .PAR_TYP(par_typ), .TX_OUT(tx),
    .BUSY(busy), .FIFO_COUNT(count)
  );

  uart_tx_buffered #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .STOP_BITS(2)) dut2 (
    .CLK(clk), .RST(rst), .BAUD_TICK(tick), .P_DATA(p_data2), .DATA_VALID(valid2),
    .DATA_READY(ready2), .PAR_EN(par_en2), .PAR_TYP(par_typ2), .TX_OUT(tx2),
    .BUSY(busy2), .FIFO_COUNT(count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; tick = 1'b0;
    p_data = '0; valid = 1'b0; par_en = 1'b0; par_typ = 1'b0;
    p_data2 = '0; valid2 = 1'b0; par_en2 = 1'b0; par_typ2 = 1'b0;

    // Reset state, checked before any clock edge.
    #1 rst = 1'b1;
    #1;
    chk("reset tx", 32'(tx), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset ready", 32'(ready), 32'd1);
    chk("reset count", 32'(count), 32'd0);
    chk("reset tx2", 32'(tx2), 32'd1);
    @(negedge clk); rst = 1'b0;

    // T1: 0xA5, even parity, one bit per clock.
    @(negedge clk);
    tick = 1'b1; p_data = 8'hA5; valid = 1'b1; par_en = 1'b1; par_typ = 1'b0;
    @(negedge clk); valid = 1'b0;
    chk("T1 count after push", 32'(count), 32'd1);
    chk("T1 tx before start", 32'(tx), 32'd1);
    chk("T1 busy before start", 32'(busy), 32'd0);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      chk($sformatf("T1 tx bit %0d", i), 32'(tx), 32'(t1_exp[i]));
      chk($sformatf("T1 busy bit %0d", i), 32'(busy), 32'd1);
    end
    @(negedge clk);
    chk("T1 tx idle", 32'(tx), 32'd1);
    chk("T1 busy idle", 32'(busy), 32'd0);

    // T2: odd parity; inputs disturbed mid-frame must not matter.
    @(negedge clk);
    p_data = 8'hA5; valid = 1'b1; par_en = 1'b1; par_typ = 1'b1;
    @(negedge clk); valid = 1'b0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      chk($sformatf("T2 tx bit %0d", i), 32'(tx), 32'(t2_exp[i]));
      if (i == 3) begin
        p_data = 8'h00; par_typ = 1'b0; par_en = 1'b0;
      end
    end
    @(negedge clk);
    chk("T2 busy idle", 32'(busy), 32'd0);

    // T3: two stop bits, no parity, 0x00 then 0xFF back to back.
    @(negedge clk);
    p_data2 = 8'h00; valid2 = 1'b1; par_en2 = 1'b0;
    @(negedge clk); p_data2 = 8'hFF;
    @(negedge clk); valid2 = 1'b0;
    chk("T3 count2 after push/pop", 32'(count2), 32'd1);
    chk("T3 tx2 bit 0", 32'(tx2), 32'(t3_exp[0]));
    for (int i = 1; i < 22; i++) begin
      @(negedge clk);
      chk($sformatf("T3 tx2 bit %0d", i), 32'(tx2), 32'(t3_exp[i]));
      chk($sformatf("T3 busy2 bit %0d", i), 32'(busy2), 32'd1);
    end
    @(negedge clk);
    chk("T3 tx2 idle", 32'(tx2), 32'd1);
    chk("T3 busy2 idle", 32'(busy2), 32'd0);
    chk("T3 count2 idle", 32'(count2), 32'd0);

    // T4: fill with ticks off, fifth word refused, then drain in order.
    tick = 1'b0; par_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      p_data = 8'(8'h11 * (i + 1)); valid = 1'b1;
      @(negedge clk);
      chk($sformatf("T4 count after push %0d", i), 32'(count), 32'((i < 4) ? i + 1 : 4));
      chk($sformatf("T4 ready after push %0d", i), 32'(ready), 32'((i < 3) ? 1 : 0));
    end
    valid = 1'b0;
    chk("T4 busy with ticks off", 32'(busy), 32'd0);
    chk("T4 tx with ticks off", 32'(tx), 32'd1);
    tick = 1'b1;
    for (int f = 0; f < 4; f++) begin
      for (int b = 0; b < 10; b++) begin
        @(negedge clk);
        fr[b] = tx;
        if (f == 0 && b == 0) begin
          chk("T4 count after first pop", 32'(count), 32'd3);
          chk("T4 ready after first pop", 32'(ready), 32'd1);
        end
      end
      chk($sformatf("T4 frame %0d", f), 32'(fr), 32'({1'b1, t4_w[f], 1'b0}));
    end
    @(negedge clk);
    chk("T4 busy drained", 32'(busy), 32'd0);
    chk("T4 count drained", 32'(count), 32'd0);

    // T5: one tick every 16 clocks; each bit must hold 16 clocks.
    tick = 1'b0; p_data = 8'h3C; valid = 1'b1; par_en = 1'b1; par_typ = 1'b0;
    @(negedge clk); valid = 1'b0;
    chk("T5 count after push", 32'(count), 32'd1);
    for (int c = 0; c < 208; c++) begin
      tick = ((c % 16) == 15);
      @(negedge clk);
      if (c >= 15 && c < 191) begin
        chk($sformatf("T5 tx clk %0d", c), 32'(tx), 32'(t5_exp[(c - 15) / 16]));
        chk($sformatf("T5 busy clk %0d", c), 32'(busy), 32'd1);
      end else begin
        chk($sformatf("T5 tx idle clk %0d", c), 32'(tx), 32'd1);
        chk($sformatf("T5 busy idle clk %0d", c), 32'(busy), 32'd0);
      end
    end

    // T6: reset during data bit 3 with two words queued.
    tick = 1'b1; par_en = 1'b0;
    p_data = 8'h81; valid = 1'b1;
    @(negedge clk); p_data = 8'h42;
    @(negedge clk); p_data = 8'h99;
    @(negedge clk); valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("T6 tx data bit 3", 32'(tx), 32'd0);
    chk("T6 count before reset", 32'(count), 32'd2);
    chk("T6 busy before reset", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("T6 tx async reset", 32'(tx), 32'd1);
    chk("T6 busy async reset", 32'(busy), 32'd0);
    chk("T6 count async reset", 32'(count), 32'd0);
    chk("T6 ready async reset", 32'(ready), 32'd1);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("T6 tx after release", 32'(tx), 32'd1);
    p_data = 8'h5A; valid = 1'b1;
    @(negedge clk); valid = 1'b0;
    chk("T6 count fresh push", 32'(count), 32'd1);
    for (int b = 0; b < 10; b++) begin
      @(negedge clk);
      chk($sformatf("T6 tx bit %0d", b), 32'(tx), 32'(t6_exp[b]));
    end
    @(negedge clk);
    chk("T6 busy idle", 32'(busy), 32'd0);
    chk("T6 count idle", 32'(count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
